// File: rtl/uart_pkg.sv
// Shared constants for the uart_tx arbiter: byte width, header default and FSM encoding.
package uart_pkg;

    localparam int BYTE_W = 8;

    localparam logic [BYTE_W-1:0] HEADER_BASE_DEF = 8'hA0;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_HDR       = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_WAIT_LOW  = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    // Header identifies the source; the sum wraps modulo 256.
    function automatic logic [BYTE_W-1:0] hdr_byte(input logic [BYTE_W-1:0] base,
                                                   input logic [BYTE_W-1:0] idx);
        return base + idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i, wrapping.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IW-1:0]      idx_o,
    output logic               found_o
);

    logic          found;
    int            pos;
    logic [IW-1:0] pos_w;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        pos     = 0;
        pos_w   = '0;
        if (en_i) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                pos = int'(ptr_i) + k;
                if (pos >= NUM_REQ) begin
                    pos = pos - NUM_REQ;
                end
                pos_w = IW'(pos);
                if (!found && req_i[pos_w]) begin
                    found          = 1'b1;
                    grant_o[pos_w] = 1'b1;
                    idx_o          = pos_w;
                end
            end
        end
        found_o = found;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin sharing of one uart_tx between NUM_REQ byte streams,
// with an optional source-identifying header byte before each packet.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int                NUM_REQ     = 4,
    parameter int                HEADER_EN   = 1,
    parameter logic [BYTE_W-1:0] HEADER_BASE = HEADER_BASE_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        grant,
    output logic [BYTE_W-1:0]         tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic [2:0]                dbg_state_o
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Handshake: tx_valid is a registered one-cycle pulse issued only while
    // uart_tx is idle; acceptance is confirmed by tx_ready falling, completion
    // by tx_ready rising. req_ready[i] is a one-cycle pulse meaning the byte
    // presented on slice i was taken; the requester advances after seeing it.

    logic [2:0]         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic               last_q, last_d;
    logic               hdr_q, hdr_d;
    logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
    logic               tx_valid_q, tx_valid_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IW-1:0]      arb_idx;
    logic               arb_found;
    logic               arb_en;

    logic               sel_valid;
    logic [BYTE_W-1:0]  sel_data;
    logic               sel_last;
    logic [IW-1:0]      rr_next;

    assign arb_en = (state_q == ST_IDLE) && tx_ready;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req_i   (req_valid),
        .ptr_i   (rr_q),
        .en_i    (arb_en),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .found_o (arb_found)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IW'(i) == idx_q) begin
                sel_valid = req_valid[i];
                sel_data  = req_data[i*BYTE_W +: BYTE_W];
                sel_last  = req_last[i];
            end
        end
    end

    assign rr_next = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        idx_d       = idx_q;
        rr_d        = rr_q;
        last_d      = last_q;
        hdr_d       = hdr_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = 1'b0;
        req_ready_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    grant_d = arb_grant;
                    idx_d   = arb_idx;
                    state_d = (HEADER_EN != 0) ? ST_HDR : ST_DATA;
                end
            end
            ST_HDR: begin
                tx_data_d  = hdr_byte(HEADER_BASE, BYTE_W'(idx_q));
                tx_valid_d = 1'b1;
                hdr_d      = 1'b1;
                state_d    = ST_WAIT_LOW;
            end
            ST_DATA: begin
                // The grant is held indefinitely while the owner has nothing to send.
                if (sel_valid) begin
                    tx_data_d   = sel_data;
                    tx_valid_d  = 1'b1;
                    req_ready_d = grant_q;
                    last_d      = sel_last;
                    hdr_d       = 1'b0;
                    state_d     = ST_WAIT_LOW;
                end
            end
            ST_WAIT_LOW: begin
                if (!tx_ready) begin
                    state_d = ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
                if (tx_ready) begin
                    if (hdr_q) begin
                        state_d = ST_DATA;
                    end else if (last_q) begin
                        grant_d = '0;
                        rr_d    = rr_next;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            idx_q       <= '0;
            rr_q        <= '0;
            last_q      <= 1'b0;
            hdr_q       <= 1'b0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            req_ready_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            idx_q       <= idx_d;
            rr_q        <= rr_d;
            last_q      <= last_d;
            hdr_q       <= hdr_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign grant       = grant_q;
    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural uart_tx busy model, queue-fed requesters
// and a scoreboard of expected {grant, byte} pairs checked at every tx_valid.
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int FRAME = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]   req_valid, req_last, req_ready, grant;
    logic [8*N-1:0] req_data;
    logic [7:0]     tx_data;
    logic           tx_valid, tx_ready;
    logic [2:0]     dbg_state;

    logic [N-1:0]   n_req_valid, n_req_last, n_req_ready, n_grant;
    logic [8*N-1:0] n_req_data;
    logic [7:0]     n_tx_data;
    logic           n_tx_valid, n_tx_ready;
    logic [2:0]     n_dbg_state;

    uart_tx_arbiter #(.NUM_REQ(N), .HEADER_EN(1), .HEADER_BASE(8'hA0)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .grant(grant), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .dbg_state_o(dbg_state)
    );

    uart_tx_arbiter #(.NUM_REQ(N), .HEADER_EN(0), .HEADER_BASE(8'hA0)) dut_nh (
        .clk(clk), .rst_n(rst_n), .req_valid(n_req_valid), .req_data(n_req_data),
        .req_last(n_req_last), .req_ready(n_req_ready), .grant(n_grant), .tx_data(n_tx_data),
        .tx_valid(n_tx_valid), .tx_ready(n_tx_ready), .dbg_state_o(n_dbg_state)
    );

    // uart_tx model: busy for one frame after accepting a byte, independent of rst_n.
    int u_cnt = 0;
    int n_cnt = 0;
    always @(posedge clk) begin
        if (tx_valid && u_cnt == 0) u_cnt <= FRAME;
        else if (u_cnt > 0) u_cnt <= u_cnt - 1;
        if (n_tx_valid && n_cnt == 0) n_cnt <= FRAME;
        else if (n_cnt > 0) n_cnt <= n_cnt - 1;
    end
    assign tx_ready   = (u_cnt == 0);
    assign n_tx_ready = (n_cnt == 0);

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Requester sources: per-requester FIFO of {last, data}.
    logic [8:0] src_mem [N][16];
    int         head [N];
    int         tail [N];
    int         rdy_cnt [N];
    logic       flush = 1'b0;

    initial begin
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
            rdy_cnt[i] = 0;
        end
    end

    task automatic load(input int r, input logic [7:0] d, input logic l);
        src_mem[r][tail[r] % 16] = {l, d};
        tail[r] = tail[r] + 1;
    endtask

    function automatic bit srcs_empty();
        for (int i = 0; i < N; i++) if (head[i] != tail[i]) return 1'b0;
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (req_ready[i] === 1'b1) begin
                rdy_cnt[i] = rdy_cnt[i] + 1;
                if (head[i] != tail[i]) head[i] = head[i] + 1;
            end
            if (flush) head[i] = tail[i];
            req_valid[i] = (head[i] != tail[i]);
            {req_last[i], req_data[i*8 +: 8]} = src_mem[i][head[i] % 16];
        end
        if (req_ready !== '0) check("ready_within_grant", {28'd0, req_ready & ~grant}, 32'd0);
    end

    // Scoreboard: every tx_valid pops one expected {grant, byte}.
    logic [11:0] exp_q[$];
    logic [11:0] mon_e;
    logic        prev_v = 1'b0;
    int          n_pulses = 0;
    logic        n_prev = 1'b0;

    always @(negedge clk) begin
        if (tx_valid === 1'b1) begin
            check("tx_ready_at_valid", {31'd0, tx_ready}, 32'd1);
            check("tx_valid_gap", {31'd0, prev_v}, 32'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_byte: got grant=%b data=%h, expected none", grant, tx_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("tx_grant_byte", {20'd0, grant, tx_data}, {20'd0, mon_e});
            end
        end
        prev_v = tx_valid;
        if (n_tx_valid === 1'b1) begin
            n_pulses++;
            check("nh_ready_at_valid", {31'd0, n_tx_ready}, 32'd1);
            check("nh_valid_gap", {31'd0, n_prev}, 32'd0);
            check("nh_byte", {24'd0, n_tx_data}, 32'h0000_00B9);
        end
        n_prev = n_tx_valid;
    end

    task automatic push(input int r, input logic [7:0] b);
        logic [3:0] g;
        g = 4'b0001 << r;
        exp_q.push_back({g, b});
    endtask

    task automatic wait_done(input string name, input int budget);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!(exp_q.size() == 0 && dbg_state == 3'd0 && srcs_empty()) && c < budget);
        if (c >= budget) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got %0d cycles pending=%0d, expected completion", name, c, exp_q.size());
            exp_q.delete();
        end
    endtask

    typedef struct packed {
        logic [1:0]  idx;
        logic [2:0]  len;
        logic [31:0] bytes;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int snap, snap0, c;
        logic [7:0] b;

        vecs[0] = '{idx: 2'd2, len: 3'd3, bytes: 32'h0033_2211};
        vecs[1] = '{idx: 2'd0, len: 3'd1, bytes: 32'h0000_005A};
        vecs[2] = '{idx: 2'd1, len: 3'd4, bytes: $urandom};
        vecs[3] = '{idx: 2'd3, len: 3'd2, bytes: 32'h0000_3CC3};

        n_req_valid = '0;
        n_req_last  = '0;
        n_req_data  = '0;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_ready", {28'd0, req_ready}, 32'd0);
        check("rst_grant", {28'd0, grant}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_state", {29'd0, dbg_state}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table of single-requester packets; last one leaves the rr pointer at 0.
        for (int v = 0; v < 4; v++) begin
            snap = rdy_cnt[vecs[v].idx];
            push(vecs[v].idx, 8'hA0 + {6'd0, vecs[v].idx});
            for (int k = 0; k < int'(vecs[v].len); k++) begin
                b = vecs[v].bytes[8*k +: 8];
                push(vecs[v].idx, b);
                load(vecs[v].idx, b, (k == int'(vecs[v].len) - 1));
            end
            wait_done("vec", 3000);
            check("vec_ready_count", rdy_cnt[vecs[v].idx] - snap, {29'd0, vecs[v].len});
            check("vec_grant_released", {28'd0, grant}, 32'd0);
        end

        // Requesters 0 and 3 together with rr=0.
        push(0, 8'hA0); push(0, 8'hD0); push(3, 8'hA3); push(3, 8'hD3);
        load(0, 8'hD0, 1'b1);
        load(3, 8'hD3, 1'b1);
        wait_done("rr0_pair", 3000);

        // Move rr to 1, then the same pair: requester 3 must win first.
        push(0, 8'hA0); push(0, 8'h01);
        load(0, 8'h01, 1'b1);
        wait_done("rr_step", 3000);
        push(3, 8'hA3); push(3, 8'hD3); push(0, 8'hA0); push(0, 8'hD0);
        load(0, 8'hD0, 1'b1);
        load(3, 8'hD3, 1'b1);
        wait_done("rr1_pair", 3000);

        // Requester 1 stalls mid-packet while requester 0 waits.
        snap0 = rdy_cnt[0];
        push(1, 8'hA1); push(1, 8'h71); push(1, 8'h72); push(0, 8'hA0); push(0, 8'h05);
        load(1, 8'h71, 1'b0);
        load(0, 8'h05, 1'b1);
        for (int p = 0; p < 5; p++) begin
            repeat (100) @(negedge clk);
            check("stall_grant_held", {28'd0, grant}, 32'h0000_0002);
        end
        check("stall_no_ready0", rdy_cnt[0] - snap0, 32'd0);
        check("stall_pending", exp_q.size(), 32'd3);
        load(1, 8'h72, 1'b1);
        wait_done("stall_resume", 3000);
        check("stall_ready0_after", rdy_cnt[0] - snap0, 32'd1);

        // Reset in WAIT_HIGH of the first data byte of a 3-byte packet.
        snap = rdy_cnt[2];
        push(2, 8'hA2); push(2, 8'h11);
        load(2, 8'h11, 1'b0);
        load(2, 8'h22, 1'b0);
        load(2, 8'h33, 1'b1);
        c = 0;
        while (!(rdy_cnt[2] - snap == 1 && dbg_state == 3'd4) && c < 2000) begin
            @(negedge clk);
            c++;
        end
        check("reset_reach_wait_high", {31'd0, (c < 2000)}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_grant", {28'd0, grant}, 32'd0);
        check("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("mid_rst_req_ready", {28'd0, req_ready}, 32'd0);
        check("mid_rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("mid_rst_state", {29'd0, dbg_state}, 32'd0);
        check("mid_rst_sb_empty", exp_q.size(), 32'd0);
        flush = 1'b1;
        repeat (2) @(negedge clk);
        flush = 1'b0;
        rst_n = 1'b1;
        // rr was 1 before reset; a fresh pointer of 0 puts requester 0 first.
        push(0, 8'hA0); push(0, 8'h0A); push(1, 8'hA1); push(1, 8'h1B);
        load(0, 8'h0A, 1'b1);
        load(1, 8'h1B, 1'b1);
        wait_done("post_reset", 4000);

        // No-header instance streams 0xB9 four times from requester 0.
        for (int k = 0; k < 4; k++) begin
            n_req_valid = 4'b0001;
            n_req_data  = {24'd0, 8'hB9};
            n_req_last  = {3'd0, (k == 3)};
            c = 0;
            do begin
                @(negedge clk);
                c++;
            end while (n_req_ready[0] !== 1'b1 && c < 1000);
            if (c >= 1000) begin
                total++;
                bad++;
                $display("FAIL nh_ready_timeout: got no req_ready after %0d cycles, expected pulse", c);
            end
        end
        n_req_valid = '0;
        n_req_last  = '0;
        repeat (300) @(negedge clk);
        check("nh_pulse_count", n_pulses, 32'd4);
        check("nh_grant_released", {28'd0, n_grant}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
